counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_pkg.sv | 14 +
 rtl/counter_ctrl_debouncer.sv | 54 +++++
 rtl/counter_ctrl.sv | 146 ++++++++++++++
 tb/tb_counter_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the run/pause counter controller: FSM state
// encoding and default timing parameters.
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } run_state_t;

   localparam int unsigned DIV_DEFAULT        = 50_000_000;
   localparam int unsigned DEB_CYCLES_DEFAULT = 500_000;

endpackage

// File: rtl/counter_ctrl_debouncer.sv
// Pushbutton conditioning: 2-flop synchronizer, stability-count debounce and
// a single-cycle press strobe on each debounced rising edge. Releases are
// debounced the same way but produce no strobe.
import counter_ctrl_pkg::*;

module debouncer #(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic [CW-1:0] stab_cnt;

   // bring the raw button into the clock domain
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= btn;
         sync_2 <= sync_1;
      end
   end

   // accept a new level only after DEB_CYCLES consecutive differing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         stab_cnt <= '0;
         level    <= 1'b0;
         press    <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_2 == level) begin
            stab_cnt <= '0;
         end else if (stab_cnt == CNT_LAST) begin
            stab_cnt <= '0;
            level    <= sync_2;
            press    <= sync_2;
         end else begin
            stab_cnt <= stab_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/direction controller for a downstream up/down counter.
// Three debounced buttons drive a small FSM; a prescaler running only in RUN
// emits one enable strobe per DIV clocks.
// Optional feature: define COUNTER_CTRL_STEP_EN to add a btn_step input that
// issues a single enable strobe while paused.
//
// state | meaning
// IDLE  | after reset, prescaler cleared, no strobes
// RUN   | prescaler counting, strobe on each wrap
// PAUSE | prescaler frozen, no strobes (except a step press when enabled)
import counter_ctrl_pkg::*;

module counter_ctrl #(
   parameter int unsigned DIV        = DIV_DEFAULT,
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_pause,
`ifdef COUNTER_CTRL_STEP_EN
   input  logic       btn_step,
`endif
   output logic       updown,
   output logic       enable,
   output logic [1:0] run_state
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   run_state_t    state_q;
   run_state_t    state_n;
   logic          updown_n;
   logic          step_pulse;
   logic [PW-1:0] presc;
   logic          up_press;
   logic          down_press;
   logic          pause_press;
   logic          step_press;
   logic          dir_press;
   logic          count_en;
   logic          presc_wrap;

   debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_up),
      .press (up_press)
   );

   debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_down),
      .press (down_press)
   );

   debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_pause),
      .press (pause_press)
   );

`ifdef COUNTER_CTRL_STEP_EN
   debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_step),
      .press (step_press)
   );
`else
   assign step_press = 1'b0;
`endif

   // up and down together cancel each other
   assign dir_press  = up_press ^ down_press;
   // a RUN cycle that is about to leave RUN neither counts nor strobes
   assign count_en   = (state_q == RUN) && (state_n == RUN);
   assign presc_wrap = (presc == PRESC_LAST);
   assign run_state  = state_q;

   // next state and direction; pause press outranks direction presses
   always_comb begin
      state_n    = state_q;
      updown_n   = updown;
      step_pulse = 1'b0;
      case (state_q)
         IDLE: begin
            if (dir_press) begin
               state_n  = RUN;
               updown_n = up_press;
            end
         end
         RUN: begin
            if (pause_press) begin
               state_n = PAUSE;
            end else if (dir_press) begin
               updown_n = up_press;
            end
         end
         PAUSE: begin
            if (pause_press) begin
               state_n = RUN;
            end else if (dir_press) begin
               state_n  = RUN;
               updown_n = up_press;
            end else if (step_press) begin
               step_pulse = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // prescaler, direction and strobe; strobe is dropped when direction flips
   always_ff @(posedge clk) begin
      if (reset) begin
         updown <= 1'b1;
         enable <= 1'b0;
         presc  <= '0;
      end else begin
         updown <= updown_n;
         enable <= ((count_en && presc_wrap) || step_pulse) && (updown_n == updown);
         if ((state_q == IDLE) && (state_n == RUN)) begin
            presc <= '0;
         end else if (count_en) begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl with DIV=4, DEB_CYCLES=3. Expected enable
// strobes (cycle, direction, state) are queued by the stimulus; a monitor pops
// one entry for every strobe the DUT produces.
module tb_counter_ctrl;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       btn_up    = 1'b0;
   logic       btn_down  = 1'b0;
   logic       btn_pause = 1'b0;
`ifdef COUNTER_CTRL_STEP_EN
   logic       btn_step  = 1'b0;
`endif
   logic       updown;
   logic       enable;
   logic [1:0] run_state;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;
   int b;

   typedef struct {
      int         cyc;
      logic       updown;
      logic [1:0] st;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   counter_ctrl #(.DIV(4), .DEB_CYCLES(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_pause (btn_pause),
`ifdef COUNTER_CTRL_STEP_EN
      .btn_step  (btn_step),
`endif
      .updown    (updown),
      .enable    (enable),
      .run_state (run_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic push_exp(input int c, input logic ud, input logic [1:0] st);
      exp_t e;
      e.cyc    = c;
      e.updown = ud;
      e.st     = st;
      exp_q.push_back(e);
   endtask

   // monitor: every strobe must match the next queued expectation
   always @(negedge clk) begin
      if (enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_enable at cycle %0d: got 1, expected 0", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_cycle", cyc, mon_e.cyc);
            check("pulse_updown", int'(updown), int'(mon_e.updown));
            check("pulse_state", int'(run_state), int'(mon_e.st));
         end
      end
   end

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      check("rst_enable", int'(enable), 0);
      check("rst_updown", int'(updown), 1);
      check("rst_state", int'(run_state), 0);
      reset = 1'b0;

      // idle with no buttons: nothing happens
      repeat (50) @(negedge clk);
      check("idle_updown", int'(updown), 1);
      check("idle_state", int'(run_state), 0);

      // bouncing up button: two-cycle highs never pass the debouncer
      for (int i = 0; i < 5; i++) begin
         btn_up = 1'b1;
         repeat (2) @(negedge clk);
         btn_up = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("bounce_state", int'(run_state), 0);
      check("bounce_updown", int'(updown), 1);

      // up press: RUN at b+6, strobes every 4 cycles from b+10
      b = cyc;
      push_exp(b + 10, 1'b1, 2'd1);
      push_exp(b + 14, 1'b1, 2'd1);
      // down press lands its direction change on the b+18 wrap: strobe dropped
      push_exp(b + 22, 1'b0, 2'd1);
      push_exp(b + 26, 1'b0, 2'd1);
      btn_up = 1'b1;
      wait_until(b + 6);
      btn_up = 1'b0;
      wait_until(b + 7);
      check("run_state", int'(run_state), 1);
      check("run_updown", int'(updown), 1);

      wait_until(b + 12);
      btn_down = 1'b1;
      wait_until(b + 17);
      check("dir_before", int'(updown), 1);
      wait_until(b + 18);
      check("dir_after", int'(updown), 0);
      btn_down = 1'b0;

      // pause press taking effect with prescaler at 2
      wait_until(b + 23);
      btn_pause = 1'b1;
      wait_until(b + 29);
      btn_pause = 1'b0;
      check("pause_state", int'(run_state), 2);
      wait_until(b + 40);
      check("paused_state", int'(run_state), 2);

      // resume: two more counts, then strobe at b+48
      btn_pause = 1'b1;
      push_exp(b + 48, 1'b0, 2'd1);
      push_exp(b + 52, 1'b0, 2'd1);
      push_exp(b + 56, 1'b0, 2'd1);
      push_exp(b + 60, 1'b0, 2'd1);
      wait_until(b + 46);
      btn_pause = 1'b0;
      check("resume_state", int'(run_state), 1);

      // pause together with up in RUN: pause wins, direction kept
      wait_until(b + 56);
      btn_pause = 1'b1;
      btn_up    = 1'b1;
      wait_until(b + 62);
      btn_pause = 1'b0;
      btn_up    = 1'b0;
      wait_until(b + 63);
      check("pause_up_state", int'(run_state), 2);
      check("pause_up_updown", int'(updown), 0);

      // up and down together in PAUSE: no change
      wait_until(b + 70);
      btn_up   = 1'b1;
      btn_down = 1'b1;
      wait_until(b + 76);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      wait_until(b + 77);
      check("updown_both_state", int'(run_state), 2);
      check("updown_both_updown", int'(updown), 0);

`ifdef COUNTER_CTRL_STEP_EN
      // step press in PAUSE: one strobe, state and prescaler untouched
      wait_until(b + 80);
      push_exp(b + 86, 1'b0, 2'd2);
      btn_step = 1'b1;
      wait_until(b + 86);
      btn_step = 1'b0;
`endif
      wait_until(b + 88);
      check("step_state", int'(run_state), 2);

      // resume with prescaler held at 1: strobe after three counts
      wait_until(b + 90);
      btn_pause = 1'b1;
      push_exp(b + 99, 1'b0, 2'd1);
      wait_until(b + 96);
      btn_pause = 1'b0;

      // reset over the b+103 wrap, with up held through reset release
      wait_until(b + 102);
      reset  = 1'b1;
      btn_up = 1'b1;
      wait_until(b + 103);
      check("midrst_enable", int'(enable), 0);
      check("midrst_state", int'(run_state), 0);
      check("midrst_updown", int'(updown), 1);
      reset = 1'b0;
      push_exp(b + 113, 1'b1, 2'd1);
      wait_until(b + 108);
      check("held_not_yet", int'(run_state), 0);
      wait_until(b + 109);
      check("held_press_state", int'(run_state), 1);
      check("held_press_updown", int'(updown), 1);
      btn_up = 1'b0;

      wait_until(b + 116);
      check("pending_pulses", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
